// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial-to-parallel receiver with a valid/ready byte output.
// Latency: the byte is presented 1 clk after the stop-bit sample, which falls ~9.5 bit times after the start edge.
// Backpressure: one holding register; a byte completed while it is still full is dropped and flagged by overrun.
//
// Ports:
//   clk            system clock, all logic on posedge
//   reset          asynchronous active-high reset, aborts any frame in progress
//   serial_in      RX line, asynchronous to clk, idles high
//   data_out       received byte, stable while data_out_valid is high
//   data_out_valid byte available, held until accepted
//   data_out_ready consumer accepts the byte when valid && ready at posedge
//   framing_error  1-clk pulse: stop bit sampled low, byte discarded
//   overrun        1-clk pulse: byte completed while holding register full, new byte dropped
module uart_receiver #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);

  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
  localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             fe_q, fe_d;
  logic             ovr_q, ovr_d;
  logic             sync1_q, sync2_q;
  logic             rx_s;
  logic             deliver;

  assign rx_s = sync2_q;

  // Two-flop synchroniser; reset to 1 so a reset never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= serial_in;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    fe_d    = 1'b0;
    ovr_d   = 1'b0;
    deliver = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Counter parked at zero so START begins counting from its entry cycle.
        cnt_d = '0;
        if (!rx_s) begin
          state_d = S_START;
        end
      end

      S_START: begin
        // Half-bit check rejects short glitches on an idle line.
        if (cnt_q == SAMPLE_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = S_DATA;
            bit_d   = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_DATA: begin
        // Full-bit spacing from the mid-start sample keeps every sample mid-bit.
        if (cnt_q == SYMBOL_LAST) begin
          cnt_d          = '0;
          shift_d[bit_q] = rx_s;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end

      S_STOP: begin
        if (cnt_q == SYMBOL_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            deliver = 1'b1;
            state_d = S_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = S_BREAK;
          end
        end
      end

      S_BREAK: begin
        // A line held low is reported once; wait for it to return high.
        cnt_d = '0;
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Holding register: an accept in the same cycle frees it for the new byte.
    if (deliver) begin
      if (!valid_q || data_out_ready) begin
        dout_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && data_out_ready) begin
      valid_d = 1'b0;
    end
  end

  assign data_out       = dout_q;
  assign data_out_valid = valid_q;
  assign framing_error  = fe_q;
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: self-checking bench for uart_receiver at a reduced clock/baud ratio (16 clk/bit).
// Latency: expected bytes are matched in order at each valid&&ready handshake.
// Backpressure: ready is driven low, high or random per test phase.
module tb_uart_receiver;

  localparam int CLK_HZ = 2_000_000;
  localparam int BAUD   = 125_000;
  localparam int BIT    = CLK_HZ / BAUD;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       serial_in = 1'b1;
  logic       data_out_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       framing_error;
  logic       overrun;

  uart_receiver #(
    .CLOCK_FREQ(CLK_HZ),
    .BAUD_RATE (BAUD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .serial_in     (serial_in),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: bytes that must appear, in order, at the handshake.
  logic [7:0] exp_q[$];
  int n_acc = 0;
  int n_fe  = 0;
  int n_ovr = 0;
  int rise_cyc = -1;
  int ready_mode = 0;   // 0: low, 1: random, 2: high

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    int         skew;
    int         rdy;
    int         exp_rx;
    int         exp_fe;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bit i ends at (i+1)*BIT*(100+skew)/100 cycles after the start edge.
  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input int skew);
    logic [9:0] bits;
    int c;
    bits = {stop_ok, d, 1'b0};
    c = 0;
    for (int i = 0; i < 10; i++) begin
      serial_in = bits[i];
      while (c < ((i + 1) * BIT * (100 + skew)) / 100) begin
        @(posedge clk);
        #1;
        c++;
      end
    end
    if (!stop_ok) begin
      wait_cycles(2 * BIT);   // line low for three bit times from the stop bit
    end
    serial_in = 1'b1;
  endtask

  // Ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       data_out_ready = 1'b0;
        1:       data_out_ready = 1'($urandom_range(0, 1));
        default: data_out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: handshake scoreboard and pulse/hold invariants.
  logic       pv, pacc, pfe, pov;
  logic [7:0] pdata;
  initial begin
    pv = 0; pacc = 0; pfe = 0; pov = 0; pdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pv = 0; pacc = 0; pfe = 0; pov = 0;
      end else begin
        if (pv && !pacc) begin
          check("hold_valid", data_out_valid, 1);
          check("hold_data", data_out, pdata);
        end
        if (data_out_valid && !pv) rise_cyc = cyc;
        if (data_out_valid && data_out_ready) begin
          n_acc++;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_byte: got %02h expected none", data_out);
          end else begin
            check("rx_data", data_out, exp_q.pop_front());
          end
        end
        if (framing_error) begin
          n_fe++;
          check("fe_width", pfe, 0);
        end
        if (overrun) begin
          n_ovr++;
          check("ovr_width", pov, 0);
        end
        if (framing_error || overrun) check("fe_ovr_excl", framing_error && overrun, 0);
        pv    = data_out_valid;
        pacc  = data_out_valid && data_out_ready;
        pdata = data_out;
        pfe   = framing_error;
        pov   = overrun;
      end
    end
  end

  vec_t vecs[8];
  int   a0, f0, o0, t0;

  initial begin
    vecs[0] = '{8'hA5, 1'b1,  0, 2, 1, 0};
    vecs[1] = '{8'h00, 1'b1,  0, 1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1,  0, 1, 1, 0};
    vecs[3] = '{8'h55, 1'b0,  0, 2, 0, 1};
    vecs[4] = '{8'h81, 1'b1,  0, 2, 1, 0};
    vecs[5] = '{8'h96, 1'b1,  3, 1, 1, 0};
    vecs[6] = '{8'h96, 1'b1, -3, 1, 1, 0};
    vecs[7] = '{8'h5A, 1'b1, -3, 2, 1, 0};

    // Reset state
    #1;
    check("rst_data", data_out, 0);
    check("rst_valid", data_out_valid, 0);
    check("rst_fe", framing_error, 0);
    check("rst_ovr", overrun, 0);
    wait_cycles(4);
    reset = 1'b0;
    wait_cycles(4);

    // Directed frames
    for (int i = 0; i < 8; i++) begin
      ready_mode = vecs[i].rdy;
      a0 = n_acc; f0 = n_fe; o0 = n_ovr;
      if (vecs[i].stop_ok) exp_q.push_back(vecs[i].data);
      t0 = cyc;
      send_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].skew);
      wait_cycles(2 * BIT);
      check($sformatf("vec%0d_rx", i), n_acc - a0, vecs[i].exp_rx);
      check($sformatf("vec%0d_fe", i), n_fe - f0, vecs[i].exp_fe);
      check($sformatf("vec%0d_ovr", i), n_ovr - o0, 0);
      if (i == 0) begin
        // Stop sample lands ~9.5 bits plus synchroniser delay after the start edge.
        n_tests++;
        if (rise_cyc - t0 < 150 || rise_cyc - t0 > 160) begin
          n_fail++;
          $display("FAIL latency: got %0d cycles expected 150..160", rise_cyc - t0);
        end
      end
    end

    // Short glitch on an idle line
    ready_mode = 2;
    a0 = n_acc; f0 = n_fe; o0 = n_ovr;
    serial_in = 1'b0;
    wait_cycles(5);
    serial_in = 1'b1;
    wait_cycles(3 * BIT);
    check("glitch_rx", n_acc - a0, 0);
    check("glitch_fe", n_fe - f0, 0);
    check("glitch_ovr", n_ovr - o0, 0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 0);
    wait_cycles(2 * BIT);
    check("post_glitch_rx", n_acc - a0, 1);

    // Overrun: two back-to-back frames with ready held low
    ready_mode = 0;
    wait_cycles(2);
    a0 = n_acc; f0 = n_fe; o0 = n_ovr;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 0);
    send_frame(8'hC3, 1'b1, 0);
    wait_cycles(BIT);
    check("ovr_count", n_ovr - o0, 1);
    check("ovr_fe", n_fe - f0, 0);
    check("ovr_valid", data_out_valid, 1);
    check("ovr_data", data_out, 8'h3C);
    check("ovr_no_acc", n_acc - a0, 0);
    ready_mode = 2;
    wait_cycles(4);
    check("ovr_drain_valid", data_out_valid, 0);
    check("ovr_drain_acc", n_acc - a0, 1);
    check("ovr_drain_q", exp_q.size(), 0);

    // Reset during bit 4 of 0xFF while a byte is pending
    ready_mode = 0;
    exp_q.push_back(8'h77);
    send_frame(8'h77, 1'b1, 0);
    wait_cycles(BIT);
    check("pre_rst_valid", data_out_valid, 1);
    serial_in = 1'b0;
    wait_cycles(BIT);
    serial_in = 1'b1;
    wait_cycles(4 * BIT + BIT / 2);
    reset = 1'b1;
    #1;
    check("mid_rst_data", data_out, 0);
    check("mid_rst_valid", data_out_valid, 0);
    check("mid_rst_fe", framing_error, 0);
    check("mid_rst_ovr", overrun, 0);
    exp_q.delete();
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(2 * BIT);
    check("post_rst_valid", data_out_valid, 0);
    ready_mode = 2;
    a0 = n_acc; f0 = n_fe; o0 = n_ovr;
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 0);
    wait_cycles(2 * BIT);
    check("post_rst_rx", n_acc - a0, 1);
    check("post_rst_fe", n_fe - f0, 0);
    check("post_rst_ovr", n_ovr - o0, 0);

    // Randomised frames: random bytes, baud skew, gaps (incl. back-to-back) and ready
    ready_mode = 1;
    a0 = n_acc; f0 = n_fe; o0 = n_ovr;
    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      int skew;
      int gap;
      d    = 8'($urandom_range(0, 255));
      skew = int'($urandom_range(0, 6)) - 3;
      gap  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 30));
      exp_q.push_back(d);
      send_frame(d, 1'b1, skew);
      if (gap > 0) wait_cycles(gap);
    end
    wait_cycles(3 * BIT);
    check("rand_rx", n_acc - a0, 20);
    check("rand_fe", n_fe - f0, 0);
    check("rand_ovr", n_ovr - o0, 0);
    check("rand_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
